// File: rtl/ycr_rst_seq_pkg.sv
// Shared types and defaults for the reset sequencer.
package ycr_rst_seq_pkg;

  typedef enum logic [2:0] {
    YCR_RST_SEQ_HOLD     = 3'd0,
    YCR_RST_SEQ_DELAY    = 3'd1,
    YCR_RST_SEQ_REL      = 3'd2,
    YCR_RST_SEQ_WAIT_ACK = 3'd3,
    YCR_RST_SEQ_RUN      = 3'd4
  } type_ycr_rst_seq_fsm_e;

  localparam int unsigned YCR_RST_SEQ_HOLD_CYC_DEF = 8;
  localparam int unsigned YCR_RST_SEQ_TMO_CYC_DEF  = 64;

  function automatic int unsigned ycr_rst_seq_idx_w(input int unsigned n_dom);
    return $clog2(n_dom);
  endfunction

endpackage

// File: rtl/ycr_rst_seq_timer.sv
// Loadable down-counter; zero_o flags that the count runs out at the coming edge.
module ycr_rst_seq_timer #(
  parameter int unsigned W       = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst_n_mux,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n_mux) begin
    if (!rst_n_mux) begin
      cnt_q <= W'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count holds the cycles still to spend, so the last one is at 1.
  assign zero_o = en_i && (cnt_q <= W'(1));

endmodule

// File: rtl/ycr_reset_seq_ctrl.sv
// Reset sequencer: holds, then releases reset domains in index order with per-domain delays.
// Optional ack timeout: define YCR_RST_SEQ_TIMEOUT_EN.
module ycr_reset_seq_ctrl
  import ycr_rst_seq_pkg::*;
#(
  parameter int unsigned N_DOM    = 4,
  parameter int unsigned DLY_W    = 4,
  parameter int unsigned HOLD_CYC = YCR_RST_SEQ_HOLD_CYC_DEF,
  parameter int unsigned TMO_CYC  = YCR_RST_SEQ_TMO_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n_mux,
  input  logic                   test_mode,
  input  logic                   test_rst_n,
  input  logic                   sys_rst_req,
  input  logic [N_DOM-1:0]       dom_rst_req,
  input  logic [N_DOM-1:0]       dom_ack,
  input  logic [N_DOM*DLY_W-1:0] dly_cfg,
  output logic [N_DOM-1:0]       dom_rst_n,
  output logic                   seq_busy,
  output logic                   seq_done,
  output logic                   seq_err,
  output logic [2:0]             dbg_state_o
);

  localparam int unsigned IDX_W   = ycr_rst_seq_idx_w(N_DOM);
  localparam int unsigned HOLD_W  = $clog2(HOLD_CYC + 1);
  localparam int unsigned HCNT_W  = (HOLD_W > DLY_W) ? HOLD_W : DLY_W;

  type_ycr_rst_seq_fsm_e state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              full_q, full_d;
  logic [N_DOM-1:0]  pend_q, pend_d;
  logic [N_DOM-1:0]  rst_q, rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              hd_load;
  logic [HCNT_W-1:0] hd_val;
  logic              hd_zero;
  logic              tmo_load;
  logic              tmo_hit;
  logic [N_DOM-1:0]  pend_all;
  logic [N_DOM-1:0]  sel_oh;
  logic [IDX_W-1:0]  sel;
  logic [IDX_W-1:0]  nxt_idx;

  // A zero delay still spends one cycle in DELAY.
  function automatic logic [HCNT_W-1:0] dly_of(input logic [N_DOM*DLY_W-1:0] cfg,
                                               input logic [IDX_W-1:0] i);
    logic [DLY_W-1:0] d;
    d = cfg[int'(i)*DLY_W +: DLY_W];
    return (d == '0) ? HCNT_W'(1) : HCNT_W'(d);
  endfunction

  assign pend_all = pend_q | dom_rst_req;
  assign nxt_idx  = idx_q + 1'b1;

  always_comb begin
    sel    = '0;
    sel_oh = '0;
    for (int i = N_DOM - 1; i >= 0; i--) begin
      if (pend_all[i]) begin
        sel = IDX_W'(i);
      end
    end
    sel_oh[sel] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    full_d   = full_q;
    // Requests during a full sequence are redundant: every domain is being reset anyway.
    pend_d   = full_q ? '0 : pend_all;
    rst_d    = rst_q;
    done_d   = 1'b0;
    err_d    = err_q;
    hd_load  = 1'b0;
    hd_val   = HCNT_W'(HOLD_CYC);
    tmo_load = 1'b0;
    if (sys_rst_req) begin
      state_d = YCR_RST_SEQ_HOLD;
      idx_d   = '0;
      full_d  = 1'b1;
      pend_d  = '0;
      rst_d   = '0;
      err_d   = 1'b0;
      hd_load = 1'b1;
    end else begin
      case (state_q)
        YCR_RST_SEQ_HOLD: begin
          if (hd_zero) begin
            state_d = YCR_RST_SEQ_DELAY;
            hd_load = 1'b1;
            hd_val  = dly_of(dly_cfg, idx_q);
          end
        end
        YCR_RST_SEQ_DELAY: begin
          if (hd_zero) begin
            state_d = YCR_RST_SEQ_REL;
          end
        end
        YCR_RST_SEQ_REL: begin
          rst_d[idx_q] = 1'b1;
          state_d      = YCR_RST_SEQ_WAIT_ACK;
          tmo_load     = 1'b1;
        end
        YCR_RST_SEQ_WAIT_ACK: begin
          if (dom_ack[idx_q] || tmo_hit) begin
            if (!dom_ack[idx_q]) begin
              err_d = 1'b1;
            end
            if (full_q && (idx_q != IDX_W'(N_DOM - 1))) begin
              idx_d   = nxt_idx;
              state_d = YCR_RST_SEQ_DELAY;
              hd_load = 1'b1;
              hd_val  = dly_of(dly_cfg, nxt_idx);
            end else begin
              state_d = YCR_RST_SEQ_RUN;
              full_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        YCR_RST_SEQ_RUN: begin
          if (pend_all != '0) begin
            state_d    = YCR_RST_SEQ_HOLD;
            idx_d      = sel;
            full_d     = 1'b0;
            pend_d     = pend_all & ~sel_oh;
            rst_d[sel] = 1'b0;
            hd_load    = 1'b1;
          end
        end
        default: begin
          state_d = YCR_RST_SEQ_HOLD;
          hd_load = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n_mux) begin
    if (!rst_n_mux) begin
      state_q <= YCR_RST_SEQ_HOLD;
      idx_q   <= '0;
      full_q  <= 1'b1;
      pend_q  <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      full_q  <= full_d;
      pend_q  <= pend_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  ycr_rst_seq_timer #(
    .W       (HCNT_W),
    .RST_VAL (HOLD_CYC)
  ) u_hd_timer (
    .clk        (clk),
    .rst_n_mux  (rst_n_mux),
    .load_i     (hd_load),
    .load_val_i (hd_val),
    .en_i       ((state_q == YCR_RST_SEQ_HOLD) || (state_q == YCR_RST_SEQ_DELAY)),
    .zero_o     (hd_zero)
  );

`ifdef YCR_RST_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);

  ycr_rst_seq_timer #(
    .W       (TMO_W),
    .RST_VAL (TMO_CYC)
  ) u_tmo_timer (
    .clk        (clk),
    .rst_n_mux  (rst_n_mux),
    .load_i     (tmo_load),
    .load_val_i (TMO_W'(TMO_CYC)),
    .en_i       (state_q == YCR_RST_SEQ_WAIT_ACK),
    .zero_o     (tmo_hit)
  );
`else
  logic unused_tmo;
  assign unused_tmo = tmo_load ^ (TMO_CYC == 0);
  assign tmo_hit    = 1'b0;
`endif

  assign dom_rst_n   = test_mode ? {N_DOM{test_rst_n}} : rst_q;
  assign seq_busy    = (state_q != YCR_RST_SEQ_RUN);
  assign seq_done    = done_q;
  assign seq_err     = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ycr_reset_seq_ctrl.sv
// Bench for ycr_reset_seq_ctrl: output events {cycle, busy, done, dom_rst_n} checked against a queue.
module tb_ycr_reset_seq_ctrl;

  localparam int W = 38;

  logic        clk = 1'b0;
  logic        rst_n_mux = 1'b0;
  logic        test_mode = 1'b0;
  logic        test_rst_n = 1'b0;
  logic        sys_rst_req = 1'b0;
  logic [3:0]  dom_rst_req = 4'b0000;
  logic [3:0]  dom_ack = 4'b0000;
  logic [15:0] dly_cfg = {4'd3, 4'd2, 4'd1, 4'd0};
  logic [3:0]  dom_rst_n;
  logic        seq_busy, seq_done, seq_err;
  logic [2:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;
  logic [5:0]   obs;
  logic [5:0]   prev_obs = 6'b100000;
  logic         mon_en = 1'b0;
  logic [3:0]   ack_d1 = 4'b0000;
  logic [3:0]   ack_mask = 4'b0000;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;

  ycr_reset_seq_ctrl dut (
    .clk         (clk),
    .rst_n_mux   (rst_n_mux),
    .test_mode   (test_mode),
    .test_rst_n  (test_rst_n),
    .sys_rst_req (sys_rst_req),
    .dom_rst_req (dom_rst_req),
    .dom_ack     (dom_ack),
    .dly_cfg     (dly_cfg),
    .dom_rst_n   (dom_rst_n),
    .seq_busy    (seq_busy),
    .seq_done    (seq_done),
    .seq_err     (seq_err),
    .dbg_state_o (dbg_state)
  );

  // Clock and cycle count since reset release.
  always #10 clk = ~clk;
  always @(posedge clk) if (rst_n_mux) cyc++;

  // Domain status follows dom_rst_n two cycles late.
  always @(negedge clk) begin
    dom_ack = ack_d1 & ~ack_mask;
    ack_d1  = dom_rst_n;
  end

  function automatic logic [W-1:0] ev(input int c, input logic b, input logic d,
                                      input logic [3:0] r);
    return {32'(c), b, d, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every change of the observed outputs must match the queue head.
  always @(negedge clk) begin
    if (mon_en) begin
      obs = {seq_busy, seq_done, dom_rst_n};
      if (obs !== prev_obs) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: cyc %0d busy/done/rst_n %b, expected no event", cyc, obs);
        end else begin
          exp_w = exp_q.pop_front();
          if ({cyc[31:0], obs} !== exp_w) begin
            errors++;
            $display("FAIL event: got cyc %0d busy/done/rst_n %b, expected cyc %0d busy/done/rst_n %b",
                     cyc, obs, exp_w[37:6], exp_w[5:0]);
          end
        end
      end
      prev_obs = obs;
    end
  end

  // Releases of a full sequence started (HOLD loaded) at posedge p, acks 2 cycles behind.
  task automatic push_full(input int p);
    exp_q.push_back(ev(p + 10, 1'b1, 1'b0, 4'b0001));
    exp_q.push_back(ev(p + 14, 1'b1, 1'b0, 4'b0011));
    exp_q.push_back(ev(p + 19, 1'b1, 1'b0, 4'b0111));
    exp_q.push_back(ev(p + 25, 1'b1, 1'b0, 4'b1111));
    exp_q.push_back(ev(p + 27, 1'b0, 1'b1, 4'b1111));
    exp_q.push_back(ev(p + 28, 1'b0, 1'b0, 4'b1111));
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic sys_req(output int p);
    @(negedge clk);
    sys_rst_req = 1'b1;
    p = cyc + 1;
    exp_q.push_back(ev(p, 1'b1, 1'b0, 4'b0000));
    @(negedge clk);
    sys_rst_req = 1'b0;
  endtask

  task automatic dom_req(input logic [3:0] r, input logic [3:0] first_rst, output int p);
    @(negedge clk);
    dom_rst_req = r;
    p = cyc + 1;
    exp_q.push_back(ev(p, 1'b1, 1'b0, first_rst));
    @(negedge clk);
    dom_rst_req = 4'b0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    int p, q, p0, p1, p2, p3;
    repeat (2) @(negedge clk);
    chk("reset_dom_rst_n", 32'(dom_rst_n), 32'h0);
    chk("reset_busy", 32'(seq_busy), 32'h1);
    chk("reset_done", 32'(seq_done), 32'h0);
    chk("reset_err", 32'(seq_err), 32'h0);

    // Power-on sequence: dom0..dom3 with delays 0,1,2,3.
    push_full(0);
    mon_en    = 1'b1;
    rst_n_mux = 1'b1;
    wait_until(40);
    chk("poweron_busy", 32'(seq_busy), 32'h0);

    // Single software reset of domain 2.
    dom_req(4'b0100, 4'b1011, p);
    exp_q.push_back(ev(p + 11, 1'b1, 1'b0, 4'b1111));
    exp_q.push_back(ev(p + 13, 1'b0, 1'b1, 4'b1111));
    exp_q.push_back(ev(p + 14, 1'b0, 1'b0, 4'b1111));
    wait_until(p + 20);

    // Two requests at once: domain 1 first, domain 3 from the pending mask.
    dom_req(4'b1010, 4'b1101, p);
    q = p + 13;
    exp_q.push_back(ev(p + 10, 1'b1, 1'b0, 4'b1111));
    exp_q.push_back(ev(p + 12, 1'b0, 1'b1, 4'b1111));
    exp_q.push_back(ev(q, 1'b1, 1'b0, 4'b0111));
    exp_q.push_back(ev(q + 12, 1'b1, 1'b0, 4'b1111));
    exp_q.push_back(ev(q + 14, 1'b0, 1'b1, 4'b1111));
    exp_q.push_back(ev(q + 15, 1'b0, 1'b0, 4'b1111));
    wait_until(q + 20);

    // System reset aborting the WAIT_ACK of domain 2.
    sys_req(p0);
    exp_q.push_back(ev(p0 + 10, 1'b1, 1'b0, 4'b0001));
    exp_q.push_back(ev(p0 + 14, 1'b1, 1'b0, 4'b0011));
    exp_q.push_back(ev(p0 + 19, 1'b1, 1'b0, 4'b0111));
    wait_until(p0 + 18);
    sys_req(p1);
    push_full(p1);
    wait_until(p1 + 35);
    chk("abort_restart_busy", 32'(seq_busy), 32'h0);

    // Domain 1 never acknowledges.
    ack_mask = 4'b0010;
    sys_req(p2);
    exp_q.push_back(ev(p2 + 10, 1'b1, 1'b0, 4'b0001));
    exp_q.push_back(ev(p2 + 14, 1'b1, 1'b0, 4'b0011));
`ifdef YCR_RST_SEQ_TIMEOUT_EN
    exp_q.push_back(ev(p2 + 81, 1'b1, 1'b0, 4'b0111));
    exp_q.push_back(ev(p2 + 87, 1'b1, 1'b0, 4'b1111));
    exp_q.push_back(ev(p2 + 89, 1'b0, 1'b1, 4'b1111));
    exp_q.push_back(ev(p2 + 90, 1'b0, 1'b0, 4'b1111));
    wait_until(p2 + 77);
    chk("tmo_err_before_expiry", 32'(seq_err), 32'h0);
    wait_until(p2 + 100);
    chk("tmo_dom_rst_n", 32'(dom_rst_n), 32'hf);
    chk("tmo_busy", 32'(seq_busy), 32'h0);
    chk("tmo_err", 32'(seq_err), 32'h1);
`else
    wait_until(p2 + 100);
    chk("noack_dom_rst_n", 32'(dom_rst_n), 32'h3);
    chk("noack_busy", 32'(seq_busy), 32'h1);
    chk("noack_err", 32'(seq_err), 32'h0);
`endif
    sys_req(p3);
    ack_mask = 4'b0000;
    push_full(p3);
    wait_until(p3 + 2);
    chk("err_cleared", 32'(seq_err), 32'h0);
    wait_until(p3 + 35);

    // Test-mode bypass, checked combinationally between clock edges.
    @(posedge clk);
    #2 test_mode = 1'b1; test_rst_n = 1'b0;
    #2 chk("test_low", 32'(dom_rst_n), 32'h0);
    test_rst_n = 1'b1;
    #2 chk("test_high", 32'(dom_rst_n), 32'hf);
    test_rst_n = 1'b0;
    #2 chk("test_low_again", 32'(dom_rst_n), 32'h0);
    chk("test_fsm_idle", 32'(seq_busy), 32'h0);
    test_mode = 1'b0;
    #2 chk("test_exit", 32'(dom_rst_n), 32'hf);

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
